// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular FIFO holding fetched {pc, instr} pairs toward decode.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic         head_valid,
   output fetch_entry_t head_data
);

   fetch_entry_t mem [2];
   logic         head;
   logic         tail;

   // Flush only rewinds the pointers; stale storage is masked by count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_valid = (count != 2'd0);
   assign head_data  = mem[head];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences imem, handles redirect/halt/fault.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   input  logic        resume,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam logic [1:0] QFULL = 2'(QDEPTH);

   state_t       state;
   state_t       next_state;
   logic [31:0]  pc;
   logic [1:0]   q_count;
   logic         redirect_take;
   logic         misaligned;
   logic         pop;
   logic         push;
   fetch_entry_t push_data;
   fetch_entry_t head_data;

   assign redirect_take = redirect_valid && (state != BOOT);
   assign misaligned    = (redirect_pc[1:0] != 2'b00);
   assign pop           = out_valid && out_ready && !redirect_take;
   assign push          = (state == FETCH) && !redirect_take && ((q_count != QFULL) || pop);
   assign push_data     = '{pc: pc, instr: imem_rdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Redirect outranks halt_req; a faulted HALT is only left by an aligned redirect.
   always_comb begin
      next_state = state;
      case (state)
         BOOT: begin
            next_state = FETCH;
         end
         FETCH: begin
            if (redirect_take) begin
               next_state = misaligned ? HALT : FETCH;
            end else if (halt_req) begin
               next_state = HALT;
            end
         end
         HALT: begin
            if (redirect_take) begin
               if (misaligned) begin
                  next_state = HALT;
               end else if (fault) begin
                  next_state = FETCH;
               end
            end else if (resume && !halt_req && !fault) begin
               next_state = FETCH;
            end
         end
         default: begin
            next_state = BOOT;
         end
      endcase
   end

   always_comb begin
      imem_req = (state == FETCH);
      halted   = (state == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= 32'd0;
      end else if (redirect_take) begin
         if (misaligned) begin
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
         end else begin
            pc    <= redirect_pc;
            fault <= 1'b0;
         end
      end else if (push) begin
         pc <= pc + PC_INC;
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_take),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .count      (q_count),
      .head_valid (out_valid),
      .head_data  (head_data)
   );

   assign imem_addr = pc;
   assign out_pc    = head_data.pc;
   assign out_instr = head_data.instr;

endmodule
